// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: entry states and tag constants.
package reservation_station_pkg;

  // Entry lifecycle: EMPTY -> WAIT -> READY -> EXEC -> EMPTY
  typedef enum logic [1:0] {
    RS_EMPTY = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_EXEC  = 2'd3
  } rs_state_e;

  // Low tag bits hold idx+1, so a tag of all zeros never names an entry
  localparam int RS_IDX_TAG_W = 2;
  // Tag value meaning "operand already present"
  localparam int RS_NULL_TAG  = 0;

endpackage

// File: rtl/reservation_station_rs_entry.sv
// One reservation-station entry: state machine, operand capture (issue bypass
// and CDB snoop) and release on broadcast of its own result tag.
module rs_entry
  import reservation_station_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAG_W-1:0]  own_tag,
  input  logic              alloc,
  input  logic [1:0]        alloc_op,
  input  logic [DATA_W-1:0] alloc_vj,
  input  logic [DATA_W-1:0] alloc_vk,
  input  logic [TAG_W-1:0]  alloc_qj,
  input  logic [TAG_W-1:0]  alloc_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              fire,
  output logic [1:0]        state,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  rs_state_e         st;
  logic [TAG_W-1:0]  qj, qk, src_qj, src_qk, nqj, nqk;
  logic [DATA_W-1:0] src_vj, src_vk, nvj, nvk;
  logic              hit_j, hit_k;

  assign state = st;

  // Operand source is the issue bus while empty, else the stored operand;
  // a matching CDB broadcast replaces the value and clears the tag.
  always_comb begin
    src_qj = (st == RS_EMPTY) ? alloc_qj : qj;
    src_qk = (st == RS_EMPTY) ? alloc_qk : qk;
    src_vj = (st == RS_EMPTY) ? alloc_vj : vj;
    src_vk = (st == RS_EMPTY) ? alloc_vk : vk;
    hit_j  = cdb_valid && (src_qj != TAG_W'(RS_NULL_TAG)) && (src_qj == cdb_tag);
    hit_k  = cdb_valid && (src_qk != TAG_W'(RS_NULL_TAG)) && (src_qk == cdb_tag);
    nqj    = hit_j ? TAG_W'(RS_NULL_TAG) : src_qj;
    nqk    = hit_k ? TAG_W'(RS_NULL_TAG) : src_qk;
    nvj    = hit_j ? cdb_data : src_vj;
    nvk    = hit_k ? cdb_data : src_vk;
  end

  // Entry state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= RS_EMPTY;
      op <= '0;
      vj <= '0;
      vk <= '0;
      qj <= '0;
      qk <= '0;
    end else begin
      case (st)
        RS_EMPTY: if (alloc) begin
          op <= alloc_op;
          vj <= nvj;
          vk <= nvk;
          qj <= nqj;
          qk <= nqk;
          st <= (nqj == TAG_W'(RS_NULL_TAG) && nqk == TAG_W'(RS_NULL_TAG)) ? RS_READY : RS_WAIT;
        end
        RS_WAIT: begin
          vj <= nvj;
          vk <= nvk;
          qj <= nqj;
          qk <= nqk;
          if (nqj == TAG_W'(RS_NULL_TAG) && nqk == TAG_W'(RS_NULL_TAG)) st <= RS_READY;
        end
        RS_READY: if (fire) st <= RS_EXEC;
        RS_EXEC:  if (cdb_valid && cdb_tag == own_tag) st <= RS_EMPTY;
        default:  st <= RS_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station top: entry allocation, dispatch select with lock, and
// optional oldest-first dispatch (macro RS_OLDEST_FIRST_EN).
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter int STATION_ID = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic [TAG_W-1:0]  issue_tag,
  output logic              is_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [1:0]        disp_op,
  output logic [DATA_W-1:0] disp_a,
  output logic [DATA_W-1:0] disp_b,
  output logic [TAG_W-1:0]  disp_tag
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-RS_IDX_TAG_W-1:0] SID = (TAG_W-RS_IDX_TAG_W)'(STATION_ID);

  logic [DEPTH-1:0][1:0]        st;
  logic [DEPTH-1:0][1:0]        op_a;
  logic [DEPTH-1:0][DATA_W-1:0] vj_a, vk_a;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_a;
  logic [DEPTH-1:0]             alloc, fire, empty_v, ready_v;
  logic [IDX_W-1:0]             free_idx, pick_idx, sel, lock_idx;
  logic                         pick_vld, lock_vld;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      assign tag_a[g]   = {SID, RS_IDX_TAG_W'(g + 1)};
      assign empty_v[g] = (st[g] == RS_EMPTY);
      assign ready_v[g] = (st[g] == RS_READY);
      assign alloc[g]   = issue_en & ~is_full & (free_idx == IDX_W'(g));
      assign fire[g]    = disp_valid & disp_ready & (sel == IDX_W'(g));

      rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_ent (
        .clk      (clk),
        .rst_n    (rst_n),
        .own_tag  (tag_a[g]),
        .alloc    (alloc[g]),
        .alloc_op (issue_op),
        .alloc_vj (issue_vj),
        .alloc_vk (issue_vk),
        .alloc_qj (issue_qj),
        .alloc_qk (issue_qk),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .fire     (fire[g]),
        .state    (st[g]),
        .op       (op_a[g]),
        .vj       (vj_a[g]),
        .vk       (vk_a[g])
      );
    end
  endgenerate

  // Lowest-index empty entry is the allocation target
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (empty_v[i]) free_idx = IDX_W'(i);
  end

  assign is_full   = ~|empty_v;
  assign issue_tag = is_full ? TAG_W'(RS_NULL_TAG) : tag_a[free_idx];

`ifdef RS_OLDEST_FIRST_EN
  logic [DEPTH-1:0][1:0] age;

  // Ages restart on allocation and saturate as later issues arrive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (issue_en && !is_full) begin
      for (int i = 0; i < DEPTH; i++)
        if (alloc[i])           age[i] <= 2'd0;
        else if (age[i] != 2'd3) age[i] <= age[i] + 2'd1;
    end
  end

  // Oldest ready entry wins; ties go to the lower index
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ready_v[i] && (!pick_vld || age[i] > age[pick_idx])) begin
        pick_idx = IDX_W'(i);
        pick_vld = 1'b1;
      end
  end
`else
  // Lowest-index ready entry wins
  always_comb begin
    pick_idx = '0;
    pick_vld = |ready_v;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready_v[i]) pick_idx = IDX_W'(i);
  end
`endif

  // A presented but unaccepted entry stays selected until the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else begin
      lock_vld <= disp_valid & ~disp_ready;
      if (disp_valid) lock_idx <= sel;
    end
  end

  assign sel        = lock_vld ? lock_idx : pick_idx;
  assign disp_valid = lock_vld | pick_vld;
  assign disp_op    = disp_valid ? op_a[sel]  : '0;
  assign disp_a     = disp_valid ? vj_a[sel]  : '0;
  assign disp_b     = disp_valid ? vk_a[sel]  : '0;
  assign disp_tag   = disp_valid ? tag_a[sel] : '0;

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds issued instructions for one functional unit (add/sub, multiply or divide) until their operands are available. It sits between the decode/issue control unit and the functional unit: it accepts an issue when its station-enable bit is set, snoops the common data bus (CDB) for pending operands, and dispatches ready instructions over a valid/ready handshake. It reports fullness back to issue control, and an entry is released when its own result tag is broadcast on the CDB.

## Interface
- DEPTH, 3: number of entries (1..3).
- DATA_W, 32: operand and result width.
- TAG_W, 4: tag width. Tag = {STATION_ID[TAG_W-3:0], idx+1 as 2 bits}. Tag 0 means "value present".
- STATION_ID, 1: upper tag bits. Must be nonzero per station and unique across stations.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_en  in  1  this station's ResStationEN bit.
- issue_op  in  2  ALUop to execute.
- issue_vj / issue_vk  in  DATA_W  operand values; used only when the matching q is 0.
- issue_qj / issue_qk  in  TAG_W  producer tags; 0 means the value is present.
- issue_tag  out  TAG_W  tag of the entry that will be allocated. Combinational; 0 when full.
- is_full  out  1  no EMPTY entry; feeds the isFull vector.
- cdb_valid  in  1  broadcast strobe.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- disp_valid  out  1  dispatch request.
- disp_ready  in  1  functional unit accepts.
- disp_op  out  2  operation of the dispatched entry.
- disp_a / disp_b  out  DATA_W  Vj / Vk of the dispatched entry.
- disp_tag  out  TAG_W  result tag of the dispatched entry.

## Operation
- Each entry has state EMPTY → WAIT → READY → EXEC → EMPTY.
- Issue: when issue_en=1 and not full, the lowest-index EMPTY entry is written.
  - Goes to READY if both q are 0 after bypass, otherwise to WAIT.
  - issue_en while full is ignored; no state changes.
- Issue bypass: if cdb_valid is high and cdb_tag equals a nonzero issue_qj/qk in the same cycle, cdb_data is captured and that q is cleared.
- CDB snoop, for every WAIT entry: on cdb_valid, any q equal to cdb_tag captures cdb_data and clears q. The entry becomes READY when both q are 0.
- Dispatch:
  - disp_valid=1 when some entry is READY or the dispatch lock is held.
  - The selected index is locked until disp_valid & disp_ready. Outputs stay stable while valid and not ready.
  - On handshake the entry goes READY → EXEC and the lock clears.
- Free: cdb_valid with cdb_tag equal to an EXEC entry's own tag sets that entry to EMPTY.
- A tag is never reused while an entry is in EXEC.
- Simultaneous events:
  - Free and issue in the same cycle: is_full uses registered state, so an issue while full is still refused that cycle.
  - Snoop and dispatch in the same cycle act on different entries and do not interact.

## Timing
- Reset: all entries EMPTY, lock cleared. Outputs: is_full=0, disp_valid=0, disp_op/a/b/tag=0, issue_tag = tag of entry 0.
- Reset mid-operation discards all entries immediately. No dispatch is issued after reset until a new issue occurs.
- Issue at edge t with operands present: disp_valid=1 in cycle t+1.
- CDB capture at edge t: entry is READY in t+1; disp_valid can assert in t+1.
- Free at edge t: is_full drops in t+1.
- is_full and disp_* decode combinationally from registered state; there is no combinational path from disp_ready to disp_valid.

## Configuration
- RS_OLDEST_FIRST_EN defined:
  - Each entry keeps a 2-bit age, reset to 0 on issue and incremented on every other issue.
  - Dispatch picks the READY entry with the greatest age.
- RS_OLDEST_FIRST_EN undefined: dispatch picks the lowest-index READY entry; no age storage is built.

## Structure
- The shared header head.v holds the entry-state encoding (RS_EMPTY/WAIT/READY/EXEC), the tag-width constants and the null tag 0, next to the existing ALU op defines.
- One sub-module, rs_entry: one entry's state machine, operand capture, CDB compare and own-tag free.
- The top level keeps allocation, dispatch select/lock and optional ages.

## Test plan
- Reset, then issue op=0, vj=5, vk=7, q=0 → issue_tag=0x5 (STATION_ID=1); one cycle later disp_valid=1, disp_a=5, disp_b=7, disp_tag=0x5.
- Issue qj=0x9, then CDB tag 0x9 with data 0x20 → no dispatch before the broadcast; disp_a=0x20 the cycle after it.
- Issue qk=0x9 in the same cycle as CDB tag 0x9 with data 3 → bypass captures 3; dispatch in the next cycle.
- Fill 3 entries → is_full=1 and a 4th issue is ignored. CDB own tag 0x6 → is_full=0 next cycle; a new issue gets tag 0x6.
- disp_ready held low for 4 cycles while a lower-index entry becomes READY → disp_tag and data unchanged until handshake.
- Assert rst_n low with 2 entries in WAIT → all outputs return to reset values; a later CDB for their tags causes no dispatch.
